// File: rtl/ysyx_25040105_pkg.sv
// Shared definitions for the ysyx_25040105 core controller: FSM state
// encodings, the default memory-response timeout and a small state helper.
package ysyx_25040105_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_FWAIT  = 3'd2,
        ST_DECODE = 3'd3,
        ST_MEM    = 3'd4,
        ST_MWAIT  = 3'd5,
        ST_WB     = 3'd6,
        ST_HALT   = 3'd7   // also the error state; timeout_err tells them apart
    } state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 256;

    function automatic logic is_wait_state(input state_e s);
        return (s == ST_FWAIT) || (s == ST_MWAIT);
    endfunction

endpackage

// File: rtl/ysyx_25040105_wdt.sv
// Memory-response watchdog: counts cycles spent waiting for a response and
// flags expiry on the last allowed waiting cycle.
module ysyx_25040105_wdt
    import ysyx_25040105_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // The count is zero in the first cycle of every wait and saturates at LIMIT.
    always_comb begin
        cnt_d = cnt_q;
        if (!waiting) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = waiting && (cnt_q == LIMIT);

endmodule

// File: rtl/ysyx_25040105_ctrl.sv
// Multi-cycle core control FSM: fetch / decode / memory / write-back sequencing
// and minstret. Define YSYX_25040105_CTRL_TIMEOUT_EN to bound memory waits.
module ysyx_25040105_ctrl
    import ysyx_25040105_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    output logic        inst_wen,
    input  logic        dec_is_load,
    input  logic        dec_is_store,
    input  logic        dec_reg_wen,
    input  logic        dec_ebreak,
    output logic        lsu_req_valid,
    input  logic        lsu_req_ready,
    input  logic        lsu_rsp_valid,
    output logic        rf_wen,
    output logic        pc_wen,
    output logic        halt,
    output logic        timeout_err,
    output logic [2:0]  state,
    output logic [31:0] minstret
);

    state_e      state_q, state_d;
    logic        wb_rf_q, wb_rf_d;
    logic [31:0] minstret_q, minstret_d;
    logic        timeout;

`ifdef YSYX_25040105_CTRL_TIMEOUT_EN
    logic err_q, err_d;

    ysyx_25040105_wdt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk    (clk),
        .rst_n  (rst_n),
        .waiting(is_wait_state(state_q)),
        .expired(timeout)
    );

    assign err_d = err_q | timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign timeout_err = err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        inst_wen = 1'b0;
        unique case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  if (imem_req_ready) state_d = ST_FWAIT;
            ST_FWAIT: begin
                if (imem_rsp_valid) begin
                    inst_wen = 1'b1;
                    state_d  = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (dec_ebreak)                      state_d = ST_HALT;
                else if (dec_is_load | dec_is_store) state_d = ST_MEM;
                else                                 state_d = ST_WB;
            end
            ST_MEM:    if (lsu_req_ready) state_d = ST_MWAIT;
            ST_MWAIT: begin
                if (lsu_rsp_valid)  state_d = ST_WB;
                else if (timeout)   state_d = ST_HALT;
            end
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
        endcase
    end

    // The write-back enable is captured in DECODE so rf_wen stays a pure
    // function of registered state.
    assign wb_rf_d    = (state_q == ST_DECODE) ? (dec_reg_wen & ~dec_is_store) : wb_rf_q;
    assign minstret_d = (state_q == ST_WB) ? minstret_q + 32'd1 : minstret_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wb_rf_q    <= 1'b0;
            minstret_q <= '0;
        end else begin
            state_q    <= state_d;
            wb_rf_q    <= wb_rf_d;
            minstret_q <= minstret_d;
        end
    end

    assign imem_req_valid = (state_q == ST_FETCH);
    assign lsu_req_valid  = (state_q == ST_MEM);
    assign pc_wen         = (state_q == ST_WB);
    assign rf_wen         = (state_q == ST_WB) & wb_rf_q;
    assign halt           = (state_q == ST_HALT);
    assign state          = state_q;
    assign minstret       = minstret_q;

endmodule

// File: tb/tb_ysyx_25040105_ctrl.sv
// Scoreboard bench for ysyx_25040105_ctrl: a memory/decoder responder feeds a
// directed program, and a monitor checks every write-back against a queue.
`timescale 1ns/1ps
module tb_ysyx_25040105_ctrl;

    localparam logic [31:0] ADDI   = 32'h0010_0093;
    localparam logic [31:0] LW     = 32'h0000_2103;
    localparam logic [31:0] SW     = 32'h0020_2223;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [2:0]  S_IDLE = 3'd0, S_FETCH = 3'd1, S_FWAIT = 3'd2,
                            S_MWAIT = 3'd5, S_HALT = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid, inst_wen;
    logic        dec_is_load, dec_is_store, dec_reg_wen, dec_ebreak;
    logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
    logic        rf_wen, pc_wen, halt, timeout_err;
    logic [2:0]  state;
    logic [31:0] minstret;
    logic [31:0] dec_inst;

    typedef struct {
        logic        rf;
        logic [31:0] mi;
        int          gap;
        int          lsu;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] prog[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          imem_rdy_dly = 0, imem_rsp_dly = 1, lsu_rdy_dly = 0, lsu_rsp_dly = 0;

    always #5 clk = ~clk;

    assign dec_is_load  = (dec_inst[6:0] == 7'h03);
    assign dec_is_store = (dec_inst[6:0] == 7'h23);
    assign dec_ebreak   = (dec_inst == EBREAK);
    assign dec_reg_wen  = (dec_inst[6:0] == 7'h13) || (dec_inst[6:0] == 7'h03);

    ysyx_25040105_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .inst_wen(inst_wen),
        .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
        .dec_reg_wen(dec_reg_wen), .dec_ebreak(dec_ebreak),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_rsp_valid(lsu_rsp_valid), .rf_wen(rf_wen), .pc_wen(pc_wen),
        .halt(halt), .timeout_err(timeout_err), .state(state), .minstret(minstret)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycles from one write-back to the next for the configured memory delays.
    function automatic int instr_cycles(input bit is_mem);
        int n;
        n = (imem_rdy_dly + 1) + (imem_rsp_dly + 1) + 1 + 1;
        if (is_mem) n += (lsu_rdy_dly + 1) + (lsu_rsp_dly + 1);
        return n;
    endfunction

    task automatic push_exp(input logic rf, input logic [31:0] mi, input int gap, input int lsu);
        exp_t e;
        e.rf = rf; e.mi = mi; e.gap = gap; e.lsu = lsu;
        exp_q.push_back(e);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (state == s) break;
        end
        check(nm, 32'(state), 32'(s));
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Memory and decoder responder: delays are counted in cycles spent in a state.
    initial begin
        logic [2:0] prev;
        int         cnt;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        lsu_req_ready  = 1'b0; lsu_rsp_valid  = 1'b0;
        dec_inst = 32'h0000_0013;
        prev = 3'd0;
        cnt  = 0;
        forever begin
            @(negedge clk);
            imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
            lsu_req_ready  = 1'b0; lsu_rsp_valid  = 1'b0;
            if (state != prev) cnt = 0;
            else               cnt++;
            prev = state;
            case (state)
                3'd1: imem_req_ready = (cnt >= imem_rdy_dly);
                3'd2: if (cnt >= imem_rsp_dly) begin
                    imem_rsp_valid = 1'b1;
                    dec_inst = (prog.size() != 0) ? prog.pop_front() : 32'h0000_0013;
                end
                3'd4: lsu_req_ready = (cnt >= lsu_rdy_dly);
                3'd5: lsu_rsp_valid = (cnt >= lsu_rsp_dly);
                default: ;
            endcase
        end
    end

    // Monitor: every write-back pops one expected entry.
    initial begin
        int   cyc, last_wb, lsu_run;
        exp_t e;
        cyc = 0; last_wb = -1; lsu_run = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                lsu_run = 0;
                last_wb = -1;
            end else begin
                if (lsu_req_valid) lsu_run++;
                if (pc_wen) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_wb", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("wb_rf_wen", 32'(rf_wen), 32'(e.rf));
                        check("wb_minstret", minstret, e.mi);
                        check("wb_lsu_req_len", 32'(lsu_run), 32'(e.lsu));
                        if (e.gap != 0) check("wb_gap", 32'(cyc - last_wb), 32'(e.gap));
                    end
                    last_wb = cyc;
                    lsu_run = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int act, n;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_imem_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_lsu_req_valid", 32'(lsu_req_valid), 32'd0);
        check("rst_inst_wen", 32'(inst_wen), 32'd0);
        check("rst_rf_wen", 32'(rf_wen), 32'd0);
        check("rst_pc_wen", 32'(pc_wen), 32'd0);
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_minstret", minstret, 32'd0);

        // addi x3, load, store, ebreak with slow LSU handshakes.
        imem_rdy_dly = 0; imem_rsp_dly = 1; lsu_rdy_dly = 2; lsu_rsp_dly = 3;
        prog.push_back(ADDI); prog.push_back(ADDI); prog.push_back(ADDI);
        prog.push_back(LW); prog.push_back(SW); prog.push_back(EBREAK);
        push_exp(1'b1, 32'd0, 0, 0);
        push_exp(1'b1, 32'd1, instr_cycles(0), 0);
        push_exp(1'b1, 32'd2, instr_cycles(0), 0);
        push_exp(1'b1, 32'd3, instr_cycles(1), 3);
        push_exp(1'b0, 32'd4, instr_cycles(1), 3);
        rst_n = 1'b1;
        check("idle_after_release", 32'(state), 32'(S_IDLE));
        @(negedge clk);
        check("fetch_after_idle", 32'(state), 32'(S_FETCH));
        check("fetch_req_valid", 32'(imem_req_valid), 32'd1);
        wait_drain(200);
        wait_state(S_HALT, 50, "ebreak_halt_state");
        check("ebreak_halt", 32'(halt), 32'd1);
        check("ebreak_minstret", minstret, 32'd5);
        check("ebreak_no_timeout_err", 32'(timeout_err), 32'd0);
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (imem_req_valid | lsu_req_valid | pc_wen | rf_wen | inst_wen) act++;
        end
        check("halt_quiet", 32'(act), 32'd0);
        check("halt_sticky", 32'(state), 32'(S_HALT));

        // Reset in the middle of a load's response wait.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        prog.push_back(ADDI); prog.push_back(LW);
        push_exp(1'b1, 32'd0, 0, 0);
        rst_n = 1'b1;
        wait_state(S_MWAIT, 100, "reach_mwait");
        check("mwait_minstret", minstret, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_lsu_req_valid", 32'(lsu_req_valid), 32'd0);
        check("async_rst_minstret", minstret, 32'd0);
        prog.push_back(EBREAK);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rerelease_idle", 32'(state), 32'(S_IDLE));
        check("rerelease_no_req", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        check("refetch_req_valid", 32'(imem_req_valid), 32'd1);
        wait_state(S_HALT, 50, "refetch_halt");
        check("refetch_minstret", minstret, 32'd0);
        wait_drain(10);

        // minstret wrap-around.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        prog.push_back(ADDI); prog.push_back(EBREAK);
        push_exp(1'b1, 32'hFFFF_FFFF, 0, 0);
        rst_n = 1'b1;
        wait_state(S_FETCH, 5, "wrap_fetch");
        force dut.minstret_q = 32'hFFFF_FFFF;
        #1 release dut.minstret_q;
        wait_drain(50);
        wait_state(S_HALT, 50, "wrap_halt");
        check("wrap_minstret", minstret, 32'd0);

        // Instruction response that never arrives.
        rst_n = 1'b0;
        imem_rsp_dly = 1000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_state(S_FWAIT, 10, "to_fwait");
        n = 1;
        for (int i = 0; i < 39; i++) begin
            @(negedge clk);
            if (state == S_FWAIT) n++;
            else break;
        end
`ifdef YSYX_25040105_CTRL_TIMEOUT_EN
        check("timeout_fwait_cycles", 32'(n), 32'd8);
        check("timeout_state", 32'(state), 32'(S_HALT));
        check("timeout_err_set", 32'(timeout_err), 32'd1);
        check("timeout_halt", 32'(halt), 32'd1);
`else
        check("no_timeout_fwait_cycles", 32'(n), 32'd40);
        check("no_timeout_state", 32'(state), 32'(S_FWAIT));
        check("no_timeout_err", 32'(timeout_err), 32'd0);
`endif
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
